// File: rtl/ws2812_rx_apb.sv
// WS2812-style NRZ receiver: decodes 24-bit pixels into an APB3-readable register file.
// Optional frame-done interrupt (IRQ port, STATUS[3] mask) when WS2812RX_IRQ_EN is defined.
module ws2812_rx_apb #(
  parameter int unsigned BIT_THRESH = 60,
  parameter int unsigned MAX_HIGH   = 110,
  parameter int unsigned RESET_LOW  = 5000,
  parameter int unsigned NUM_PIXELS = 24
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        DIN
`ifdef WS2812RX_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  localparam int unsigned CNT_MAX = (RESET_LOW > MAX_HIGH) ? RESET_LOW : MAX_HIGH;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LOW_C   = CW'(RESET_LOW);
  localparam logic [CW-1:0] RST_LOW_M1  = CW'(RESET_LOW - 1);
  localparam logic [CW-1:0] MAX_HIGH_M1 = CW'(MAX_HIGH - 1);
  localparam logic [CW-1:0] THRESH_C    = CW'(BIT_THRESH);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [4:0]    NPIX_C      = 5'(NUM_PIXELS);
  localparam logic [4:0]    STATUS_IDX  = 5'd31;

  typedef enum logic [1:0] {ST_SYNC, ST_LOW, ST_HIGH, ST_ERR} state_e;

  state_e          state_q, state_d;
  logic            din_meta_q, din_sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [4:0]      pix_cnt_q, pix_cnt_d;
  logic [23:0]     shift_q, shift_d;
  logic            bits_seen_q, bits_seen_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [23:0]     wr_data_q, wr_data_d;
  logic [23:0]     pix_q [NUM_PIXELS];
  logic [23:0]     pix_d [NUM_PIXELS];
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            fmt_q, fmt_d;
  logic [7:0]      last_cnt_q, last_cnt_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [31:0]     prdata_q, prdata_d;

  logic            done_set, ovf_set, fmt_set, new_bit;
  logic            wr_acc, rd_setup, st_wr;
  logic [4:0]      idx;
  logic [31:0]     rd_word;
  logic            mask_bit;
  logic            unused_ok;

`ifdef WS2812RX_IRQ_EN
  logic irq_mask_q, irq_mask_d, irq_q, irq_d;
  assign mask_bit = irq_mask_q;
  assign IRQ      = irq_q;
`else
  assign mask_bit = 1'b0;
`endif

  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign PRDATA    = prdata_q;
  assign unused_ok = ^{PADDR[31:7], PADDR[1:0], PWDATA[31:3]};

  assign idx      = PADDR[6:2];
  assign wr_acc   = PSEL & PENABLE & PWRITE;
  assign rd_setup = PSEL & ~PENABLE & ~PWRITE;
  assign st_wr    = wr_acc & (idx == STATUS_IDX);

  // Line decoder; all edges are taken from din_sync_q against the current level state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    shift_d     = shift_q;
    bits_seen_d = bits_seen_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    last_cnt_d  = last_cnt_q;
    frame_cnt_d = frame_cnt_q;
    done_set    = 1'b0;
    ovf_set     = 1'b0;
    fmt_set     = 1'b0;
    new_bit     = 1'b0;
    case (state_q)
      ST_SYNC, ST_ERR: begin
        if (din_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q >= RST_LOW_M1) begin
          state_d = ST_LOW;
          cnt_d   = RST_LOW_C;
          if (state_q == ST_ERR) begin
            bit_cnt_d   = '0;
            pix_cnt_d   = '0;
            bits_seen_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LOW: begin
        if (din_sync_q) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          if (cnt_q != RST_LOW_C) cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == RST_LOW_M1 && bits_seen_q) begin
            if (bit_cnt_q != '0) fmt_set = 1'b1;
            last_cnt_d  = {3'b000, pix_cnt_q};
            frame_cnt_d = frame_cnt_q + 16'd1;
            done_set    = 1'b1;
            pix_cnt_d   = '0;
            bit_cnt_d   = '0;
            bits_seen_d = 1'b0;
          end
        end
      end
      ST_HIGH: begin
        if (!din_sync_q) begin
          state_d     = ST_LOW;
          cnt_d       = CNT_ONE;
          bits_seen_d = 1'b1;
          new_bit     = (cnt_q > THRESH_C);
          if (pix_cnt_q == NPIX_C) begin
            ovf_set = 1'b1;
          end else begin
            // Right shift puts the first received bit at bit 0 after 24 bits.
            shift_d = {new_bit, shift_q[23:1]};
            if (bit_cnt_q == 5'd23) begin
              wr_en_d   = 1'b1;
              wr_addr_d = pix_cnt_q;
              wr_data_d = shift_d;
              pix_cnt_d = pix_cnt_q + 5'd1;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end else if (cnt_q >= MAX_HIGH_M1) begin
          state_d = ST_ERR;
          cnt_d   = '0;
          fmt_set = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // Register file, sticky flags and APB read path.
  always_comb begin
    pix_d = pix_q;
    if (wr_en_q) pix_d[wr_addr_q] = wr_data_q;

    done_d = (done_q & ~(st_wr & PWDATA[0])) | done_set;
    ovf_d  = (ovf_q  & ~(st_wr & PWDATA[1])) | ovf_set;
    fmt_d  = (fmt_q  & ~(st_wr & PWDATA[2])) | fmt_set;

    rd_word = '0;
    if (idx < NPIX_C) begin
      rd_word = {8'h00, pix_q[idx]};
    end else if (idx == STATUS_IDX) begin
      rd_word = {frame_cnt_q, last_cnt_q, 4'h0, mask_bit, fmt_q, ovf_q, done_q};
    end
    prdata_d = rd_setup ? rd_word : prdata_q;
  end

`ifdef WS2812RX_IRQ_EN
  always_comb begin
    irq_mask_d = st_wr ? PWDATA[3] : irq_mask_q;
    irq_d      = done_q & irq_mask_q;
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end
`endif

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      din_meta_q  <= 1'b0;
      din_sync_q  <= 1'b0;
      state_q     <= ST_SYNC;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      shift_q     <= '0;
      bits_seen_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int unsigned i = 0; i < NUM_PIXELS; i++) pix_q[i] <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      fmt_q       <= 1'b0;
      last_cnt_q  <= '0;
      frame_cnt_q <= '0;
      prdata_q    <= '0;
    end else begin
      din_meta_q  <= DIN;
      din_sync_q  <= din_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      shift_q     <= shift_d;
      bits_seen_q <= bits_seen_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      pix_q       <= pix_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      fmt_q       <= fmt_d;
      last_cnt_q  <= last_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      prdata_q    <= prdata_d;
    end
  end

endmodule

// File: tb/tb_ws2812_rx_apb.sv
// Scoreboard bench for ws2812_rx_apb: randomized pixel frames on DIN, APB readback
// checked against a frame-level reference model.
module tb_ws2812_rx_apb;
  localparam int          NP      = 24;
  localparam int          RL      = 5000;
  localparam logic [31:0] ST_ADDR = 32'h0000_007C;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        DIN = 1'b0;
`ifdef WS2812RX_IRQ_EN
  logic        IRQ;
`endif

  ws2812_rx_apb #(
    .BIT_THRESH(60),
    .MAX_HIGH  (110),
    .RESET_LOW (RL),
    .NUM_PIXELS(NP)
  ) dut (
    .PCLK   (PCLK),
    .PRESERN(PRESERN),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .DIN    (DIN)
`ifdef WS2812RX_IRQ_EN
    ,
    .IRQ    (IRQ)
`endif
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] exp;
    string       name;
  } rd_t;
  rd_t sb[$];

  // Monitor: every APB read access phase pops one expectation.
  always begin
    @(posedge PCLK);
    #1;
    if (PSEL && PENABLE && !PWRITE) begin
      if (sb.size() == 0) begin
        check("unexpected_read", PRDATA, 32'hxxxx_xxxx);
      end else begin
        rd_t e;
        e = sb.pop_front();
        check(e.name, PRDATA, e.exp);
      end
    end
  end

  // Reference model: frame-level view of what the register file should hold.
  logic [23:0] m_pix [NP];
  bit          m_done, m_ovf, m_fmt, m_mask;
  int          m_last, m_fcnt;
  bit          m_bits[$];
  bit          track = 1'b1;

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_pix[i] = '0;
    m_done = 0; m_ovf = 0; m_fmt = 0; m_mask = 0;
    m_last = 0; m_fcnt = 0;
    m_bits.delete();
  endtask

  task automatic model_pixels(input int full);
    logic [23:0] w;
    for (int p = 0; p < full && p < NP; p++) begin
      for (int k = 0; k < 24; k++) w[k] = m_bits[p*24 + k];
      m_pix[p] = w;
    end
  endtask

  task automatic model_frame_end();
    int n, full;
    n = m_bits.size();
    if (n == 0) return;
    full = n / 24;
    model_pixels(full);
    if (n > NP*24) m_ovf = 1;
    else if (n % 24 != 0) m_fmt = 1;
    m_last = (full > NP) ? NP : full;
    m_fcnt = (m_fcnt + 1) % 65536;
    m_done = 1;
    m_bits.delete();
  endtask

  task automatic model_frame_err();
    model_pixels(m_bits.size() / 24);
    m_fmt = 1;
    m_bits.delete();
  endtask

  function automatic logic [31:0] status_exp();
    logic [15:0] fc;
    logic [7:0]  lc;
    fc = m_fcnt[15:0];
    lc = m_last[7:0];
    return {fc, lc, 4'h0, m_mask, m_fmt, m_ovf, m_done};
  endfunction

  // APB tasks, called on a negedge.
  task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    rd_t e;
    e.exp = exp; e.name = name;
    sb.push_back(e);
    PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = addr;
    @(negedge PCLK) PENABLE = 1;
    @(negedge PCLK) begin PSEL = 0; PENABLE = 0; end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = addr; PWDATA = data;
    @(negedge PCLK) PENABLE = 1;
    @(negedge PCLK) begin PSEL = 0; PENABLE = 0; PWRITE = 0; end
  endtask

  task automatic status_write(input logic [31:0] v);
    apb_write(ST_ADDR, v);
    if (v[0]) m_done = 0;
    if (v[1]) m_ovf = 0;
    if (v[2]) m_fmt = 0;
`ifdef WS2812RX_IRQ_EN
    m_mask = v[3];
`endif
  endtask

  task automatic read_pix(input int i);
    apb_read(32'(i*4), {8'h00, m_pix[i]}, $sformatf("pix%0d", i));
  endtask

  // Line drive: fast mode uses randomized legal pulse widths.
  task automatic send_bit(input bit b, input bit fast, input bit no_low);
    int hi, lo;
    if (!fast) begin
      hi = b ? 81 : 41;
      lo = b ? 44 : 84;
    end else begin
      hi = b ? int'($urandom_range(62, 64)) : int'($urandom_range(2, 4));
      lo = int'($urandom_range(2, 4));
    end
    if (track) m_bits.push_back(b);
    DIN = 1;
    repeat (hi) @(negedge PCLK);
    DIN = 0;
    if (!no_low) repeat (lo) @(negedge PCLK);
  endtask

  task automatic send_pixel(input logic [23:0] w, input bit fast, input bit no_low_last);
    for (int k = 0; k < 24; k++) send_bit(w[k], fast, (k == 23) && no_low_last);
  endtask

  task automatic gap();
    repeat (RL + int'($urandom_range(10, 40))) @(negedge PCLK);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge PCLK);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pready", {31'h0, PREADY}, 32'h1);
    check("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
`ifdef WS2812RX_IRQ_EN
    check("rst_irq", {31'h0, IRQ}, 32'h0);
`endif
    PRESERN = 1;
    repeat (RL + 20) @(negedge PCLK);
    apb_read(ST_ADDR, status_exp(), "status_init");
    read_pix(0);
`ifdef WS2812RX_IRQ_EN
    status_write(32'h8);
`endif

    // Three pixels at nominal timing.
    send_pixel(24'hA5F00F, 0, 0);
    send_pixel(24'h000001, 0, 0);
    send_pixel(24'hFFFFFF, 0, 0);
    gap();
    model_frame_end();
    for (int i = 0; i < 3; i++) read_pix(i);
    apb_read(ST_ADDR, status_exp(), "status_three");
`ifdef WS2812RX_IRQ_EN
    check("irq_three", {31'h0, IRQ}, 32'h1);
`endif
    apb_read(32'(24*4), 32'h0, "unmapped24");
    apb_write(32'h0, $urandom);
    apb_write(32'(30*4), $urandom);
    read_pix(0);
    apb_read(32'(30*4), 32'h0, "unmapped30");

    // End of frame lands on the same edge as a DONE W1C: the set wins.
    send_pixel(24'($urandom), 1, 0);
    send_pixel(24'($urandom), 1, 1);
    repeat (RL) @(negedge PCLK);
    status_write(32'h1);
    model_frame_end();
    apb_read(ST_ADDR, status_exp(), "status_race");
    status_write(32'h1);
`ifdef WS2812RX_IRQ_EN
    check("irq_lag_hold", {31'h0, IRQ}, 32'h1);
    @(negedge PCLK);
    check("irq_lag_clear", {31'h0, IRQ}, 32'h0);
`endif
    apb_read(ST_ADDR, status_exp(), "status_w1c");

    // Overflow: 30 pixels into 24 slots.
    status_write(32'h7);
    for (int p = 0; p < 30; p++) send_pixel(24'h123456, 1, 0);
    gap();
    model_frame_end();
    for (int i = 0; i < NP; i++) read_pix(i);
    apb_read(ST_ADDR, status_exp(), "status_ovf");
    status_write(32'h7);

    // 30 bits: one pixel plus a dropped partial.
    for (int k = 0; k < 30; k++) send_bit(1'($urandom), 1, 0);
    gap();
    model_frame_end();
    read_pix(0);
    read_pix(1);
    apb_read(ST_ADDR, status_exp(), "status_partial");
    status_write(32'h7);

    // Over-long high pulse mid-pixel, then a clean frame after the gap.
    for (int k = 0; k < 5; k++) send_bit(1'($urandom), 1, 0);
    DIN = 1;
    repeat (200) @(negedge PCLK);
    DIN = 0;
    model_frame_err();
    repeat (100) @(negedge PCLK);
    apb_read(ST_ADDR, status_exp(), "status_err");
    gap();
    send_pixel(24'($urandom), 1, 0);
    send_pixel(24'($urandom), 1, 0);
    gap();
    model_frame_end();
    read_pix(0);
    read_pix(1);
    apb_read(ST_ADDR, status_exp(), "status_after_err");

    // Reset during the 12th bit; the rest of that stream must be ignored.
    for (int k = 0; k < 11; k++) send_bit(1'($urandom), 1, 0);
    DIN = 1;
    repeat (30) @(negedge PCLK);
    PRESERN = 0;
    model_reset();
    repeat (3) @(negedge PCLK);
    check("midrst_prdata", PRDATA, 32'h0);
    check("midrst_pready", {31'h0, PREADY}, 32'h1);
    check("midrst_pslverr", {31'h0, PSLVERR}, 32'h0);
`ifdef WS2812RX_IRQ_EN
    check("midrst_irq", {31'h0, IRQ}, 32'h0);
`endif
    PRESERN = 1;
    repeat (40) @(negedge PCLK);
    DIN = 0;
    repeat (5) @(negedge PCLK);
    track = 0;
    for (int k = 0; k < 12; k++) send_bit(1'($urandom), 1, 0);
    send_pixel(24'($urandom), 1, 0);
    gap();
    track = 1;
    apb_read(ST_ADDR, status_exp(), "status_postrst");
    read_pix(0);
    send_pixel(24'($urandom), 1, 0);
    gap();
    model_frame_end();
    read_pix(0);
    apb_read(ST_ADDR, status_exp(), "status_resync");

    repeat (4) @(negedge PCLK);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
